// File: rtl/alu_pkg.sv
// Shared types for the ALU family: operation encodings and the status-flag vector.
package alu_pkg;

  localparam int FLAG_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_SLL = 3'd2,
    ALU_SRA = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_EQ  = 3'd7
  } alu_mode_e;

  typedef struct packed {
    logic v;
    logic n;
    logic c;
    logic z;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus {V,N,C,Z} flags for one operand pair.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_mode_e        mode_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o
);

  localparam int SHW = $clog2(WIDTH);

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  logic [SHW-1:0]          sh;
  logic [WIDTH:0]          add_ext;
  logic [WIDTH:0]          sub_ext;
  logic [WIDTH:0]          sll_ext;
  logic signed [WIDTH:0]   sra_ext;
  logic [WIDTH-1:0]        res;
  logic                    c_flag;
  logic                    v_flag;

  assign sh      = b_i[SHW-1:0];
  assign add_ext = {1'b0, a_i} + {1'b0, b_i};
  assign sub_ext = {1'b0, a_i} - {1'b0, b_i};
  // One guard bit on each shifter catches the last bit shifted out; it stays 0 for sh=0.
  assign sll_ext = {1'b0, a_i} << sh;
  assign sra_ext = $signed({a_i, 1'b0}) >>> sh;

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (mode_i)
      ALU_ADD: begin
        res    = add_ext[WIDTH-1:0];
        c_flag = add_ext[WIDTH];
        v_flag = add_ovf(a_i[WIDTH-1], b_i[WIDTH-1], add_ext[WIDTH-1]);
      end
      ALU_SUB: begin
        res    = sub_ext[WIDTH-1:0];
        c_flag = sub_ext[WIDTH];
        v_flag = sub_ovf(a_i[WIDTH-1], b_i[WIDTH-1], sub_ext[WIDTH-1]);
      end
      ALU_SLL: begin
        res    = sll_ext[WIDTH-1:0];
        c_flag = sll_ext[WIDTH];
      end
      ALU_SRA: begin
        res    = sra_ext[WIDTH:1];
        c_flag = sra_ext[0];
      end
      ALU_AND: res = a_i & b_i;
      ALU_OR:  res = a_i | b_i;
      ALU_XOR: res = a_i ^ b_i;
      ALU_EQ:  res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
    endcase
  end

  assign result_o  = res;
  assign flags_o.v = v_flag;
  assign flags_o.n = res[WIDTH-1];
  assign flags_o.c = c_flag;
  assign flags_o.z = (res == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: operand register, then result/flag register, with
// valid/ready handshakes on both sides and a combinational ready path.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [FLAG_W-1:0] out_flags
);

  logic             vld_p1_q, vld_p1_d;
  logic [WIDTH-1:0] a_p1_q, a_p1_d;
  logic [WIDTH-1:0] b_p1_q, b_p1_d;
  alu_mode_e        mode_p1_q, mode_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [WIDTH-1:0] res_p2_q, res_p2_d;
  alu_flags_t       flags_p2_q, flags_p2_d;

  logic             s2_load;
  logic             in_fire;
  logic [WIDTH-1:0] core_res;
  alu_flags_t       core_flags;

  assign s2_load  = vld_p1_q && (!vld_p2_q || out_ready);
  assign in_ready = !vld_p1_q || s2_load;
  assign in_fire  = in_valid && in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (a_p1_q),
    .b_i      (b_p1_q),
    .mode_i   (mode_p1_q),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  always_comb begin
    vld_p1_d   = vld_p1_q;
    a_p1_d     = a_p1_q;
    b_p1_d     = b_p1_q;
    mode_p1_d  = mode_p1_q;
    vld_p2_d   = vld_p2_q;
    res_p2_d   = res_p2_q;
    flags_p2_d = flags_p2_q;

    if (in_fire) begin
      vld_p1_d  = 1'b1;
      a_p1_d    = in_a;
      b_p1_d    = in_b;
      mode_p1_d = alu_mode_e'(in_mode);
    end else if (s2_load) begin
      vld_p1_d  = 1'b0;
    end

    if (s2_load) begin
      vld_p2_d   = 1'b1;
      res_p2_d   = core_res;
      flags_p2_d = core_flags;
    end else if (out_ready) begin
      vld_p2_d   = 1'b0;
    end
  end

  // Stage 1: operand capture (data registers need no reset, valid does).
  always_ff @(posedge clk) begin
    if (reset) vld_p1_q <= 1'b0;
    else       vld_p1_q <= vld_p1_d;
    a_p1_q    <= a_p1_d;
    b_p1_q    <= b_p1_d;
    mode_p1_q <= mode_p1_d;
  end

  // Stage 2: result/flags; cleared on reset so the output bus reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2_q   <= 1'b0;
      res_p2_q   <= '0;
      flags_p2_q <= '0;
    end else begin
      vld_p2_q   <= vld_p2_d;
      res_p2_q   <= res_p2_d;
      flags_p2_q <= flags_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = res_p2_q;
  assign out_flags = flags_p2_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed vector table, backpressure and reset sequences,
// a WIDTH=16 instance, and a random stream against an integer reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_data;
  logic [2:0] in_mode;
  logic [3:0] out_flags;

  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_a16, in_b16, out_data16;
  logic [2:0]  in_mode16;
  logic [3:0]  out_flags16;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16), .in_b(in_b16), .in_mode(in_mode16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .out_flags(out_flags16)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for WIDTH=8, written with plain integer arithmetic.
  function automatic logic [11:0] model(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, sh, r;
    logic c, v;
    logic [7:0] d;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    sh = int'(b[2:0]);
    r = 0; c = 1'b0; v = 1'b0;
    case (m)
      3'd0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      3'd1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      3'd2: begin r = ua << sh; c = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1); end
      3'd3: begin r = sa >>> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      3'd4: r = ua & ub;
      3'd5: r = ua | ub;
      3'd6: r = ua ^ ub;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    d = r[7:0];
    return {v, d[7], c, (d == 8'h00), d};
  endfunction

  // Scoreboard: records accepted beats at the falling edge and checks outputs in order.
  logic [11:0] exp_q[$];
  bit          sb_en = 1'b0;
  int          n_in = 0, n_out = 0;
  logic        stall_prev = 1'b0;
  logic [11:0] stall_val = '0;
  logic [11:0] exp_v;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else if (sb_en) begin
      if (out_valid && stall_prev) chk("stall_hold", {out_flags, out_data}, stall_val);
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_flags, out_data};
      if (out_valid && out_ready) begin
        n_out++;
        chk("sb_has_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          chk($sformatf("sb_out%0d", n_out), {out_flags, out_data}, exp_v);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_mode, in_a, in_b));
        n_in++;
      end
    end
  end

  typedef struct {
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic [3:0] f;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    int acc, n_out0, n_in0, seen;
    logic [7:0] held;

    //          mode     a      b      data   {V,N,C,Z}
    vecs[0]  = '{ALU_ADD, 8'h7F, 8'h01, 8'h80, 4'b1100};
    vecs[1]  = '{ALU_ADD, 8'hFF, 8'h01, 8'h00, 4'b0011};
    vecs[2]  = '{ALU_SUB, 8'h05, 8'h07, 8'hFE, 4'b0110};
    vecs[3]  = '{ALU_SRA, 8'h90, 8'hF3, 8'hF2, 4'b0100};
    vecs[4]  = '{ALU_SLL, 8'h81, 8'h01, 8'h02, 4'b0010};
    vecs[5]  = '{ALU_SLL, 8'h5A, 8'h00, 8'h5A, 4'b0000};
    vecs[6]  = '{ALU_EQ,  8'h3C, 8'h3C, 8'h01, 4'b0000};
    vecs[7]  = '{ALU_EQ,  8'h3C, 8'h3D, 8'h00, 4'b0001};
    vecs[8]  = '{ALU_XOR, 8'hAA, 8'hAA, 8'h00, 4'b0001};
    vecs[9]  = '{ALU_SUB, 8'h80, 8'h01, 8'h7F, 4'b1000};
    vecs[10] = '{ALU_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vecs[11] = '{ALU_OR,  8'hF0, 8'h0F, 8'hFF, 4'b0100};
    vecs[12] = '{ALU_SRA, 8'h40, 8'h07, 8'h00, 4'b0011};
    vecs[13] = '{ALU_SLL, 8'h01, 8'h07, 8'h80, 4'b0100};

    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = '0; out_ready = 1'b1;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_mode16 = '0; out_ready16 = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_flags", out_flags, 0);
    reset = 1'b0;

    // Directed table, one beat at a time with out_ready high.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_mode = vecs[i].mode; in_a = vecs[i].a; in_b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_lat1_valid", i), out_valid, 0);
      tick();
      chk($sformatf("vec%0d_lat2_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].d);
      chk($sformatf("vec%0d_flags", i), out_flags, vecs[i].f);
    end
    tick();

    // WIDTH=16 instance: two back-to-back beats.
    in_valid16 = 1'b1; in_mode16 = ALU_SRA; in_a16 = 16'h8000; in_b16 = 16'h000F;
    tick();
    in_mode16 = ALU_ADD; in_a16 = 16'hFFFF; in_b16 = 16'h0001;
    tick();
    in_valid16 = 1'b0;
    chk("w16_sra_valid", out_valid16, 1);
    chk("w16_sra_data", out_data16, 32'hFFFF);
    chk("w16_sra_flags", out_flags16, 4'b0100);
    tick();
    chk("w16_add_valid", out_valid16, 1);
    chk("w16_add_data", out_data16, 32'h0000);
    chk("w16_add_flags", out_flags16, 4'b0011);

    // Backpressure: six back-to-back ADDs, consumer stalled for the first four cycles.
    stall_prev = 1'b0;
    sb_en  = 1'b1;
    n_out0 = n_out;
    acc    = 0;
    for (int cyc = 0; cyc < 40 && acc < 6; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = 1'b1; in_mode = ALU_ADD;
      in_a = 8'(acc * 16 + 3); in_b = 8'(acc + 1);
      #1;
      if (cyc == 2 || cyc == 3) chk($sformatf("bp_ready_low_c%0d", cyc), in_ready, 0);
      if (cyc == 2) held = out_data;
      if (cyc == 3) chk("bp_data_stable", out_data, held);
      if (cyc == 4) chk("bp_two_accepts", acc, 2);
      if (in_ready) acc++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_accepts", acc, 6);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    chk("bp_outputs", n_out - n_out0, 6);
    chk("bp_queue_empty", exp_q.size(), 0);
    sb_en = 1'b0;

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = ALU_ADD; in_a = 8'h11; in_b = 8'h22;
    tick();
    in_a = 8'h33; in_b = 8'h44;
    tick();
    in_valid = 1'b0;
    chk("full_out_valid", out_valid, 1);
    chk("full_in_ready", in_ready, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_flags", out_flags, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("no_stale_beats", seen, 0);

    // Random stream with random valid/ready toggling.
    stall_prev = 1'b0;
    sb_en  = 1'b1;
    n_in0  = n_in;
    n_out0 = n_out;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 3'($urandom_range(0, 7));
      in_a      = 8'($urandom_range(0, 255));
      in_b      = 8'($urandom_range(0, 255));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_in_out_count", n_out - n_out0, n_in - n_in0);
    sb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
